// File: rtl/naneye_stream_gen.sv
// NanEye sensor-stream generator: Manchester frames (frame sync, pixel words, line sync) on one pin.
// Define NANEYE_GEN_JITTER_EN to build the optional per-half-bit timing jitter driven by JITTER_ON.
module naneye_stream_gen #(
    parameter int C_ROWS       = 320,
    parameter int C_COLUMNS    = 320,
    parameter int C_HALF_DIV   = 3,
    parameter int C_LSYNC_BITS = 8,
    parameter int C_FSYNC_HALF = 64,
    parameter int D_WIDTH      = 10
) (
    input  logic        CLOCK,
    input  logic        RESET_N,
    input  logic        START,
    input  logic        CONTINUOUS,
    input  logic [1:0]  PATTERN,
    input  logic        JITTER_ON,
    output logic        SER_OUT,
    output logic        SER_OUT_EN,
    output logic        FRAME_START,
    output logic        LINE_END,
    output logic        FRAME_DONE,
    output logic [15:0] ROW_CNT
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FSYNC = 3'd1;
    localparam logic [2:0] S_PIXEL = 3'd2;
    localparam logic [2:0] S_LSYNC = 3'd3;
    localparam logic [2:0] S_FEND  = 3'd4;
    localparam int         TW      = $clog2(C_HALF_DIV + 2);
    localparam int         WW      = D_WIDTH + 2;

    // x^16+x^14+x^13+x^11+1, right-shifting Fibonacci form
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    endfunction

    logic [2:0]    state_q, state_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [15:0]   idx_q, idx_d;
    logic          ph_q, ph_d;
    logic [15:0]   col_q, col_d;
    logic [15:0]   row_q, row_d;
    logic [WW-1:0] word_q, word_d;
    logic [15:0]   lfsr_q, lfsr_d;
    logic [1:0]    pat_q, pat_d;
    logic          cont_q, cont_d;
    logic          ser_q, en_q, fs_q, le_q, fd_q;
    logic [15:0]   rowo_q;
    logic          ser_d, le_d, load, active, hb_end, enter;
    logic [TW-1:0] hlen;

`ifdef NANEYE_GEN_JITTER_EN
    logic [TW-1:0] hlen_q, hlen_nxt;
    logic [15:0]   jlfsr_q, jlfsr_d;
    logic          draw;

    // A new half-bit starts on frame entry and on every half-bit boundary that stays in the frame.
    assign draw = enter || (hb_end && (state_d != S_FEND));
    assign hlen = hlen_q;

    always_comb begin
        jlfsr_d  = jlfsr_q;
        hlen_nxt = TW'(C_HALF_DIV);
        if (draw && JITTER_ON) begin
            jlfsr_d = lfsr_step(jlfsr_q);
            case (jlfsr_q[1:0])
                2'b00:   hlen_nxt = TW'(C_HALF_DIV - 1);
                2'b11:   hlen_nxt = TW'(C_HALF_DIV + 1);
                default: hlen_nxt = TW'(C_HALF_DIV);
            endcase
        end
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            hlen_q  <= TW'(C_HALF_DIV);
            jlfsr_q <= 16'h1D0F;
        end else begin
            jlfsr_q <= jlfsr_d;
            if (draw) hlen_q <= hlen_nxt;
        end
    end
`else
    logic unused_jitter;
    assign unused_jitter = JITTER_ON;
    assign hlen          = TW'(C_HALF_DIV);
`endif

    assign active = (state_q == S_FSYNC) || (state_q == S_PIXEL) || (state_q == S_LSYNC);
    assign hb_end = active && (tmr_q == hlen - TW'(1));
    // START at frame end behaves like a held CONTINUOUS; CONTINUOUS must survive the whole frame.
    assign enter  = ((state_q == S_IDLE) && START) ||
                    ((state_q == S_FEND) && ((cont_q && CONTINUOUS) || START));

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        idx_d   = idx_q;
        ph_d    = ph_q;
        col_d   = col_q;
        row_d   = row_q;
        word_d  = word_q;
        lfsr_d  = lfsr_q;
        pat_d   = pat_q;
        cont_d  = cont_q;
        load    = 1'b0;
        le_d    = 1'b0;
        if (active) tmr_d = hb_end ? '0 : tmr_q + TW'(1);
        case (state_q)
            S_IDLE, S_FEND: begin
                if (enter) begin
                    state_d = S_FSYNC;
                    tmr_d   = '0;
                    idx_d   = '0;
                    ph_d    = 1'b0;
                    row_d   = '0;
                    col_d   = '0;
                    pat_d   = PATTERN;
                    cont_d  = CONTINUOUS;
                end else if (state_q == S_FEND) begin
                    state_d = S_IDLE;
                end
            end
            S_FSYNC: if (hb_end) begin
                if (idx_q == 16'(C_FSYNC_HALF - 1)) begin
                    state_d = S_PIXEL;
                    idx_d   = '0;
                    load    = 1'b1;
                end else begin
                    idx_d = idx_q + 16'd1;
                end
            end
            S_PIXEL: if (hb_end) begin
                ph_d = ~ph_q;
                if (ph_q) begin
                    word_d = word_q << 1;
                    if (idx_q == 16'(WW - 1)) begin
                        idx_d = '0;
                        if (col_q == 16'(C_COLUMNS - 1)) begin
                            state_d = S_LSYNC;
                            col_d   = '0;
                        end else begin
                            col_d = col_q + 16'd1;
                            load  = 1'b1;
                        end
                    end else begin
                        idx_d = idx_q + 16'd1;
                    end
                end
            end
            S_LSYNC: if (hb_end) begin
                ph_d = ~ph_q;
                if (ph_q) begin
                    if (idx_q == 16'(C_LSYNC_BITS - 1)) begin
                        idx_d = '0;
                        le_d  = 1'b1;
                        if (row_q == 16'(C_ROWS - 1)) begin
                            state_d = S_FEND;
                        end else begin
                            row_d   = row_q + 16'd1;
                            state_d = S_PIXEL;
                            load    = 1'b1;
                        end
                    end else begin
                        idx_d = idx_q + 16'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Word = start '1', data MSB first, stop '0'; shifted out MSB first.
        if (load) begin
            case (pat_q)
                2'd0:    word_d = {1'b1, D_WIDTH'(col_d), 1'b0};
                2'd1:    word_d = {1'b1, D_WIDTH'(row_d), 1'b0};
                2'd2:    word_d = {1'b1, {D_WIDTH{row_d[0] ^ col_d[0]}}, 1'b0};
                default: begin
                    word_d = {1'b1, D_WIDTH'(lfsr_q), 1'b0};
                    lfsr_d = lfsr_step(lfsr_q);
                end
            endcase
        end
    end

    always_comb begin
        case (state_q)
            S_FSYNC: ser_d = 1'b1;
            S_PIXEL: ser_d = word_q[WW-1] ^ ph_q;
            S_LSYNC: ser_d = ph_q;
            default: ser_d = 1'b0;
        endcase
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= S_IDLE;
            tmr_q   <= '0;
            idx_q   <= '0;
            ph_q    <= 1'b0;
            col_q   <= '0;
            row_q   <= '0;
            word_q  <= '0;
            lfsr_q  <= 16'hACE1;
            pat_q   <= '0;
            cont_q  <= 1'b0;
            ser_q   <= 1'b0;
            en_q    <= 1'b0;
            fs_q    <= 1'b0;
            le_q    <= 1'b0;
            fd_q    <= 1'b0;
            rowo_q  <= '0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            idx_q   <= idx_d;
            ph_q    <= ph_d;
            col_q   <= col_d;
            row_q   <= row_d;
            word_q  <= word_d;
            lfsr_q  <= lfsr_d;
            pat_q   <= pat_d;
            cont_q  <= cont_d;
            ser_q   <= ser_d;
            en_q    <= active;
            fs_q    <= (state_q == S_FSYNC) && (idx_q == '0) && (tmr_q == '0);
            le_q    <= le_d;
            fd_q    <= (state_q == S_FEND);
            rowo_q  <= row_q;
        end
    end

    assign SER_OUT     = ser_q;
    assign SER_OUT_EN  = en_q;
    assign FRAME_START = fs_q;
    assign LINE_END    = le_q;
    assign FRAME_DONE  = fd_q;
    assign ROW_CNT     = rowo_q;
endmodule
